// File: rtl/systolic_mac_pe.sv
// systolic_mac_pe: one processing element of the systolic matrix-multiply array.
//
// Purpose:
//   - Pipelined signed multiply-accumulate qualified by in_valid.
//   - Registered forwarding of data/weight/valid to the east/south neighbours.
//   - Drain state machine (IDLE/ACCUM/FLUSH/DRAIN/PASS) that emits the accumulator
//     onto a registered result chain, then passes upstream results through.
//
// Ports:
//   clock, reset_n          clock, asynchronous active-low reset
//   in_valid                data_in/weight_in carry a MAC operand pair this cycle
//   data_in, weight_in      signed operands from the west/north neighbours
//   clear                   synchronous accumulator/overflow clear, kills in-flight products
//   drain_req               level request to drain the result and pass the chain through
//   result_in(_valid)       result chain input from the upstream PE
//   data_out, weight_out    data_in/weight_in delayed one cycle
//   out_valid               in_valid delayed one cycle
//   result_out(_valid)      registered result chain output
//   busy                    not IDLE, or a valid product is in the multiplier pipeline
//   overflow                sticky signed accumulate overflow
//
// Parameters: DATA_W (operand width), ACC_W (>= 2*DATA_W), MULT_STAGES (1..4).
//
// Build option: define SYSTOLIC_PE_SATURATE_EN to clamp the accumulator on signed
// overflow instead of wrapping.

module systolic_mac_pe #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ACC_W       = 40,
  parameter int unsigned MULT_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] weight_in,
  input  logic              clear,
  input  logic              drain_req,
  input  logic [ACC_W-1:0]  result_in,
  input  logic              result_in_valid,
  output logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] weight_out,
  output logic              out_valid,
  output logic [ACC_W-1:0]  result_out,
  output logic              result_valid,
  output logic              busy,
  output logic              overflow
);

  localparam int unsigned ProdW     = 2 * DATA_W;
  localparam int unsigned LastStage = MULT_STAGES - 1;

  typedef enum logic [2:0] {
    StIdle,
    StAccum,
    StFlush,
    StDrain,
    StPass
  } state_e;

  state_e r_state, w_state_next;

  logic [DATA_W-1:0]       r_data_fwd, r_weight_fwd;
  logic                    r_valid_fwd;
  logic signed [ProdW-1:0] r_prod [MULT_STAGES];
  logic [MULT_STAGES-1:0]  r_pipe_valid, w_pipe_valid_next;
  logic signed [ACC_W-1:0] r_acc, w_acc_next;
  logic [ACC_W-1:0]        r_result, w_result_next;
  logic                    r_result_valid, w_result_valid_next;
  logic                    r_overflow, w_overflow_next;
  logic                    r_busy, w_busy_next;

  logic signed [ProdW-1:0] w_mult;
  logic signed [ACC_W-1:0] w_prod_ext, w_sum;
  logic                    w_accepting, w_entry_valid, w_accum_en, w_add_ovf, w_pipe_early;

`ifdef SYSTOLIC_PE_SATURATE_EN
  localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  // Full-width signed product; operands are widened first so no bits are lost.
  assign w_mult = ProdW'($signed(data_in)) * ProdW'($signed(weight_in));

  // New operands only count while accumulating; otherwise their valid is dropped
  // on entry while the data still flows down the pipeline.
  assign w_accepting   = (r_state == StIdle) || (r_state == StAccum);
  assign w_entry_valid = in_valid && w_accepting;

  // Products already in flight when FLUSH starts are still accumulated.
  assign w_accum_en = r_pipe_valid[LastStage] &&
                      ((r_state == StIdle) || (r_state == StAccum) || (r_state == StFlush));

  assign w_prod_ext = ACC_W'(r_prod[LastStage]);
  assign w_sum      = r_acc + w_prod_ext;
  assign w_add_ovf  = (r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                      (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

  // Valid products in any stage other than the last one. The last stage is consumed
  // on this edge, so FLUSH may leave as soon as the earlier stages are empty.
  always_comb begin
    w_pipe_early = 1'b0;
    for (int unsigned i = 0; i < LastStage; i++) begin
      w_pipe_early = w_pipe_early | r_pipe_valid[i];
    end
  end

  always_comb begin
    w_pipe_valid_next = '0;
    if (!clear) begin
      w_pipe_valid_next[0] = w_entry_valid;
      for (int unsigned i = 1; i < MULT_STAGES; i++) begin
        w_pipe_valid_next[i] = r_pipe_valid[i-1];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (!clear) begin
          if (drain_req) begin
            w_state_next = StFlush;
          end else if (w_accum_en) begin
            w_state_next = StAccum;
          end
        end
      end
      StAccum: begin
        if (clear) begin
          w_state_next = StIdle;
        end else if (drain_req) begin
          w_state_next = StFlush;
        end
      end
      StFlush: begin
        if (clear || !w_pipe_early) begin
          w_state_next = StDrain;
        end
      end
      StDrain: w_state_next = StPass;
      StPass: begin
        if (!drain_req) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_acc_next      = r_acc;
    w_overflow_next = r_overflow;
    if (clear) begin
      w_acc_next      = '0;
      w_overflow_next = 1'b0;
    end else if (r_state == StDrain) begin
      w_acc_next = '0;
    end else if (w_accum_en) begin
      w_acc_next = w_sum;
      if (w_add_ovf) begin
        w_overflow_next = 1'b1;
`ifdef SYSTOLIC_PE_SATURATE_EN
        // Both addends share a sign on overflow; clamp toward that sign.
        w_acc_next = w_prod_ext[ACC_W-1] ? AccMin : AccMax;
`endif
      end
    end
  end

  always_comb begin
    w_result_next       = r_result;
    w_result_valid_next = 1'b0;
    if (r_state == StDrain) begin
      w_result_next       = clear ? '0 : r_acc;
      w_result_valid_next = 1'b1;
    end else if ((r_state == StPass) && drain_req) begin
      w_result_next       = result_in;
      w_result_valid_next = result_in_valid;
    end
  end

  assign w_busy_next = (w_state_next != StIdle) || (|w_pipe_valid_next);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= StIdle;
      r_data_fwd     <= '0;
      r_weight_fwd   <= '0;
      r_valid_fwd    <= 1'b0;
      r_pipe_valid   <= '0;
      r_acc          <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_overflow     <= 1'b0;
      r_busy         <= 1'b0;
      for (int unsigned i = 0; i < MULT_STAGES; i++) begin
        r_prod[i] <= '0;
      end
    end else begin
      r_state        <= w_state_next;
      r_data_fwd     <= data_in;
      r_weight_fwd   <= weight_in;
      r_valid_fwd    <= in_valid;
      r_pipe_valid   <= w_pipe_valid_next;
      r_acc          <= w_acc_next;
      r_result       <= w_result_next;
      r_result_valid <= w_result_valid_next;
      r_overflow     <= w_overflow_next;
      r_busy         <= w_busy_next;
      r_prod[0]      <= w_mult;
      for (int unsigned i = 1; i < MULT_STAGES; i++) begin
        r_prod[i] <= r_prod[i-1];
      end
    end
  end

  assign data_out     = r_data_fwd;
  assign weight_out   = r_weight_fwd;
  assign out_valid    = r_valid_fwd;
  assign result_out   = r_result;
  assign result_valid = r_result_valid;
  assign busy         = r_busy;
  assign overflow     = r_overflow;

endmodule
